// File: rtl/agc_mem_arbiter_if.sv
// Bus bundle between the CPU sequencer, the counter-increment unit, the shared
// memory port and the arbiter; the arbiter takes the slave view.
interface agc_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [14:0] cpu_wdata;
  logic        cpu_done;
  logic [14:0] cpu_rdata;
  logic        cnt_req;
  logic        cnt_op;
  logic [11:0] cnt_addr;
  logic        cnt_done;
  logic        cnt_ovf;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [14:0] mem_wdata;
  logic [14:0] mem_rdata;
  logic        arb_busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cnt_req, cnt_op, cnt_addr,
    input  mem_rdata,
    output cpu_done, cpu_rdata, cnt_done, cnt_ovf,
    output mem_we, mem_addr, mem_wdata, arb_busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cnt_req, cnt_op, cnt_addr,
    output mem_rdata,
    input  cpu_done, cpu_rdata, cnt_done, cnt_ovf,
    input  mem_we, mem_addr, mem_wdata, arb_busy
  );
endinterface

// File: rtl/agc_mem_arbiter.sv
// Shares one memory port between the CPU sequencer and the counter-cell
// increment unit, capping counter bursts while the CPU is kept waiting.
module agc_mem_arbiter #(
  parameter int CNT_BURST_MAX = 3
) (
  input logic              clk,
  input logic              reset,
  agc_mem_arbiter_if.slave bus
);
  localparam int BW = (CNT_BURST_MAX < 1) ? 1 : $clog2(CNT_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(CNT_BURST_MAX);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CPU_ACC = 2'd1;
  localparam logic [1:0] ST_CNT_RD  = 2'd2;
  localparam logic [1:0] ST_CNT_WR  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [14:0]   hold_q, hold_d;
  logic [14:0]   cpu_rdata_q, cpu_rdata_d;
  logic [15:0]   cnt_res;
  logic          cnt_wins;

  // Ones-complement counter step: {overflow, new value}; +/-0 both step away from zero.
  function automatic logic [15:0] cnt_update(input logic [14:0] h, input logic op);
    logic [15:0] r;
    r = {1'b0, h};
    if (op == 1'b0) begin
      if (h == 15'h3FFF) begin
        r = {1'b1, 15'h0000};
      end else if (h == 15'h7FFF) begin
        r = {1'b0, 15'h0001};
      end else begin
        r = {1'b0, h + 15'h0001};
      end
    end else begin
      if (h == 15'h4000) begin
        r = {1'b1, 15'h7FFF};
      end else if (h == 15'h0000) begin
        r = {1'b0, 15'h7FFE};
      end else begin
        r = {1'b0, h - 15'h0001};
      end
    end
    return r;
  endfunction

  assign cnt_res  = cnt_update(hold_q, bus.cnt_op);
  assign cnt_wins = bus.cnt_req && (!bus.cpu_req || (burst_cnt_q < BURST_MAX));

  // Next-state, burst accounting and data capture.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    hold_d      = hold_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_wins) begin
          state_d = ST_CNT_RD;
          if (!bus.cpu_req) begin
            burst_cnt_d = '0;
          end else if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end else begin
            burst_cnt_d = burst_cnt_q;
          end
        end else if (bus.cpu_req) begin
          state_d     = ST_CPU_ACC;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = '0;
        end
      end
      ST_CPU_ACC: begin
        state_d = ST_IDLE;
        if (!bus.cpu_we) begin
          cpu_rdata_d = bus.mem_rdata;
        end else begin
          cpu_rdata_d = cpu_rdata_q;
        end
      end
      ST_CNT_RD: begin
        hold_d  = bus.mem_rdata;
        state_d = ST_CNT_WR;
      end
      ST_CNT_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      hold_q      <= 15'h0000;
      cpu_rdata_q <= 15'h0000;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      hold_q      <= hold_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Memory port and done strobes decoded from the current state only.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 12'h000;
    bus.mem_wdata = 15'h0000;
    bus.cpu_done  = 1'b0;
    bus.cnt_done  = 1'b0;
    bus.cnt_ovf   = 1'b0;
    case (state_q)
      ST_CPU_ACC: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_we    = bus.cpu_we;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_done  = 1'b1;
      end
      ST_CNT_RD: begin
        bus.mem_addr = bus.cnt_addr;
      end
      ST_CNT_WR: begin
        bus.mem_addr  = bus.cnt_addr;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = cnt_res[14:0];
        bus.cnt_done  = 1'b1;
        bus.cnt_ovf   = cnt_res[15];
      end
      default: begin
        bus.mem_we = 1'b0;
      end
    endcase
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_agc_mem_arbiter.sv
// Directed bench for agc_mem_arbiter: table-driven counter and CPU vectors
// plus hand-written fairness and reset-abort sequences.
module tb_agc_mem_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  agc_mem_arbiter_if bus ();

  agc_mem_arbiter #(.CNT_BURST_MAX(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [14:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [14:0] pl_data;

  assign bus.mem_rdata = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory model with a bench-side preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  typedef struct {
    logic        op;
    logic [11:0] addr;
    logic [14:0] h;
    logic [14:0] exp_val;
    logic        exp_ovf;
  } cnt_vec_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [14:0] wdata;
    logic [14:0] pre;
    logic [14:0] exp_rdata;
  } cpu_vec_t;

  cnt_vec_t cnt_tab [0:9];
  cpu_vec_t cpu_tab [0:3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [14:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic run_cnt(input int i, input cnt_vec_t v);
    preload(v.addr, v.h);
    bus.cnt_addr = v.addr;
    bus.cnt_op   = v.op;
    bus.cnt_req  = 1'b1;
    tick();
    @(negedge clk);
    chk($sformatf("cnt%0d_rd_busy", i), 32'(bus.arb_busy), 32'd1);
    chk($sformatf("cnt%0d_rd_we", i), 32'(bus.mem_we), 32'd0);
    chk($sformatf("cnt%0d_rd_addr", i), 32'(bus.mem_addr), 32'(v.addr));
    chk($sformatf("cnt%0d_rd_done", i), 32'(bus.cnt_done), 32'd0);
    tick();
    @(negedge clk);
    chk($sformatf("cnt%0d_wr_we", i), 32'(bus.mem_we), 32'd1);
    chk($sformatf("cnt%0d_wr_data", i), 32'(bus.mem_wdata), 32'(v.exp_val));
    chk($sformatf("cnt%0d_wr_done", i), 32'(bus.cnt_done), 32'd1);
    chk($sformatf("cnt%0d_wr_ovf", i), 32'(bus.cnt_ovf), 32'(v.exp_ovf));
    chk($sformatf("cnt%0d_wr_cpudone", i), 32'(bus.cpu_done), 32'd0);
    tick();
    bus.cnt_req = 1'b0;
    @(negedge clk);
    chk($sformatf("cnt%0d_idle_busy", i), 32'(bus.arb_busy), 32'd0);
    chk($sformatf("cnt%0d_idle_ovf", i), 32'(bus.cnt_ovf), 32'd0);
    chk($sformatf("cnt%0d_mem", i), 32'(mem[v.addr]), 32'(v.exp_val));
  endtask

  task automatic run_cpu(input int i, input cpu_vec_t v);
    preload(v.addr, v.pre);
    bus.cpu_addr  = v.addr;
    bus.cpu_we    = v.we;
    bus.cpu_wdata = v.wdata;
    bus.cpu_req   = 1'b1;
    tick();
    @(negedge clk);
    chk($sformatf("cpu%0d_done", i), 32'(bus.cpu_done), 32'd1);
    chk($sformatf("cpu%0d_addr", i), 32'(bus.mem_addr), 32'(v.addr));
    chk($sformatf("cpu%0d_we", i), 32'(bus.mem_we), 32'(v.we));
    chk($sformatf("cpu%0d_wdata", i), 32'(bus.mem_wdata), 32'(v.wdata));
    chk($sformatf("cpu%0d_cntdone", i), 32'(bus.cnt_done), 32'd0);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk($sformatf("cpu%0d_done_low", i), 32'(bus.cpu_done), 32'd0);
    chk($sformatf("cpu%0d_busy", i), 32'(bus.arb_busy), 32'd0);
    chk($sformatf("cpu%0d_rdata", i), 32'(bus.cpu_rdata), 32'(v.exp_rdata));
    chk($sformatf("cpu%0d_mem", i), 32'(mem[v.addr]), v.we ? 32'(v.wdata) : 32'(v.pre));
  endtask

  initial begin
    int grants [0:7];
    int exp_order [0:7];
    int n;
    int run;
    int max_run;
    int both_seen;
    int done_seen;

    checks = 0;
    errors = 0;
    pl_en = 1'b0; pl_addr = 12'h000; pl_data = 15'h0000;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h000; bus.cpu_wdata = 15'h0000;
    bus.cnt_req = 1'b0; bus.cnt_op = 1'b0; bus.cnt_addr = 12'h000;

    cnt_tab[0] = '{1'b0, 12'h020, 15'h3FFF, 15'h0000, 1'b1};
    cnt_tab[1] = '{1'b0, 12'h020, 15'h7FFF, 15'h0001, 1'b0};
    cnt_tab[2] = '{1'b1, 12'h021, 15'h0000, 15'h7FFE, 1'b0};
    cnt_tab[3] = '{1'b1, 12'h021, 15'h4000, 15'h7FFF, 1'b1};
    cnt_tab[4] = '{1'b0, 12'h100, 15'h0005, 15'h0006, 1'b0};
    cnt_tab[5] = '{1'b1, 12'h101, 15'h0005, 15'h0004, 1'b0};
    cnt_tab[6] = '{1'b0, 12'h102, 15'h7FFE, 15'h7FFF, 1'b0};
    cnt_tab[7] = '{1'b1, 12'h103, 15'h3FFF, 15'h3FFE, 1'b0};
    cnt_tab[8] = '{1'b0, 12'h104, 15'h4000, 15'h4001, 1'b0};
    cnt_tab[9] = '{1'b1, 12'hFFF, 15'h7FFF, 15'h7FFE, 1'b0};

    cpu_tab[0] = '{1'b0, 12'h010, 15'h0000, 15'h1234, 15'h1234};
    cpu_tab[1] = '{1'b1, 12'h011, 15'h0ABC, 15'h0000, 15'h1234};
    cpu_tab[2] = '{1'b0, 12'hFFF, 15'h5555, 15'h7FFF, 15'h7FFF};
    cpu_tab[3] = '{1'b1, 12'h000, 15'h2AAA, 15'h1111, 15'h7FFF};

    exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};

    // Outputs must be zero under reset before any clock edge.
    reset = 1'b1;
    #2;
    chk("rst_busy", 32'(bus.arb_busy), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst_dones", 32'({bus.cpu_done, bus.cnt_done, bus.cnt_ovf}), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.arb_busy), 32'd0);

    for (int i = 0; i < 10; i++) run_cnt(i, cnt_tab[i]);
    for (int i = 0; i < 4; i++) run_cpu(i, cpu_tab[i]);

    // Fairness from reset with both requests held continuously.
    preload(12'h200, 15'h0000);
    preload(12'h300, 15'h0055);
    reset = 1'b1;
    bus.cnt_addr = 12'h200; bus.cnt_op = 1'b0; bus.cnt_req = 1'b1;
    bus.cpu_addr = 12'h300; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    tick();
    #1;
    chk("fair_rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("fair_idle", 32'(bus.arb_busy), 32'd0);
    @(negedge clk);
    chk("fair_first_addr", 32'(bus.mem_addr), 32'h200);
    chk("fair_first_busy", 32'(bus.arb_busy), 32'd1);
    for (int k = 0; k < 8; k++) grants[k] = -1;
    n = 0; run = 0; max_run = 0; both_seen = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (bus.cpu_done && bus.cnt_done) both_seen++;
      if (bus.cnt_done) begin
        grants[n] = 0; n++; run++;
        if (run > max_run) max_run = run;
      end else if (bus.cpu_done) begin
        grants[n] = 1; n++; run = 0;
      end
    end
    chk("fair_count", 32'(n), 32'd8);
    chk("fair_both_done", 32'(both_seen), 32'd0);
    chk("fair_max_run", 32'(max_run), 32'd3);
    for (int k = 0; k < 8; k++) chk($sformatf("fair_grant%0d", k), 32'(grants[k]), 32'(exp_order[k]));
    tick();
    bus.cnt_req = 1'b0;
    bus.cpu_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    chk("fair_drain_busy", 32'(bus.arb_busy), 32'd0);
    chk("fair_cnt_mem", 32'(mem[12'h200]), 32'd6);
    chk("fair_cpu_rdata", 32'(bus.cpu_rdata), 32'h55);

    // Reset asserted in the middle of CNT_WR aborts the write.
    preload(12'h050, 15'h0100);
    bus.cnt_addr = 12'h050; bus.cnt_op = 1'b0; bus.cnt_req = 1'b1;
    tick();
    tick();
    chk("abort_pre_we", 32'(bus.mem_we), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_we", 32'(bus.mem_we), 32'd0);
    chk("abort_done", 32'(bus.cnt_done), 32'd0);
    chk("abort_busy", 32'(bus.arb_busy), 32'd0);
    chk("abort_rdata", 32'(bus.cpu_rdata), 32'd0);
    bus.cnt_req = 1'b0;
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.cnt_done || bus.arb_busy) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_mem", 32'(mem[12'h050]), 32'h100);
    chk("abort_busy_after", 32'(bus.arb_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
